desafio_exec: RTL
=================

# desafio_exec

Challenge executor that consumes one 60-bit challenge word from the challenge ROM and runs it to completion. It sits directly downstream of the ROM: the game controller drives the ROM address, then pulses `iniciar`. This block latches the word, drives LEDs and servo, and checks player input. Input is either a 4-character serial answer or a run of in-range distance measurements. It reports `acerto` or `erro` back to the controller.

## Interface
- `TIMEOUT_CYCLES`, 50_000_000: cycles allowed per challenge before forced error (1 s at 50 MHz).
- `CONSEC`, 3: consecutive in-range measurements required in sensor mode (1..15).
- `clock` in 1: system clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start pulse; sampled only in IDLE.
- `palavra` in 60: challenge word.
  - [59:58] opcode
  - [57:54] leds
  - [53:52] pos_inicial
  - [51:40] lim_inf (3-digit BCD)
  - [39:28] lim_sup (3-digit BCD)
  - [27:0] expected, four 7-bit ASCII chars, first char in [27:21]
- `char_valid` in 1: one-cycle strobe from the serial receiver.
- `char_in` in 7: ASCII character, valid with `char_valid`.
- `medida_pronto` in 1: one-cycle strobe from the distance-sensor interface.
- `medida` in 12: distance in 3-digit BCD, valid with `medida_pronto`.
- `medir` out 1: one-cycle measurement request.
- `leds` out 4: challenge LEDs.
- `servo_en` out 1: servo drive enable.
- `servo_pos` out 2: servo position code.
- `indice` out 2: index of the next expected char.
- `ativo` out 1: challenge in progress.
- `pronto` out 1: one-cycle done pulse.
- `acerto` out 1: held result, success.
- `erro` out 1: held result, failure.
- `estouro` out 1: held flag, error was caused by timeout.

## Operation
- States: IDLE, CARREGA, ESPERA_CHAR, MEDE, ESPERA_MEDIDA, FIM.
- IDLE:
  - `ativo`=0.
  - On `iniciar`: clear `acerto`/`erro`/`estouro`, register `palavra` into an internal word register, go to CARREGA.
  - `palavra` is ignored in every other state.
- CARREGA (1 cycle):
  - Drive `leds` from the registered field.
  - If opcode is 01 or 10: `servo_en`=1 and `servo_pos`=pos_inicial. Otherwise both are 0.
  - Clear the timeout counter, `indice`, and the consecutive counter.
  - Opcode 00/01/10 → ESPERA_CHAR. Opcode 11 → MEDE.
- ESPERA_CHAR, on `char_valid`:
  - Compare `char_in` to expected char `indice` (0→[27:21], 1→[20:14], 2→[13:7], 3→[6:0]).
  - Mismatch → `erro`, FIM.
  - Match with `indice`=3 → `acerto`, FIM.
  - Any other match → `indice`+1.
- MEDE: `medir`=1 for exactly this cycle, then ESPERA_MEDIDA.
- ESPERA_MEDIDA, on `medida_pronto`:
  - The measurement is in range iff every nibble is ≤9 AND lim_inf ≤ `medida` ≤ lim_sup, compared as unsigned 12-bit packed BCD.
  - In range: counter+1. If the counter reaches `CONSEC` → `acerto`, FIM. Otherwise → MEDE.
  - Out of range: counter cleared, → MEDE.
  - A sensor challenge therefore never errors except by timeout.
- Timeout:
  - A counter runs in ESPERA_CHAR, MEDE and ESPERA_MEDIDA.
  - When it reaches `TIMEOUT_CYCLES`-1: `erro`=1, `estouro`=1, → FIM.
  - Timeout has priority over a same-cycle `char_valid`/`medida_pronto`.
- FIM (1 cycle):
  - `pronto`=1, `ativo`=0.
  - `leds`, `servo_en`, `servo_pos` cleared.
  - → IDLE.
- `acerto`/`erro`/`estouro` hold until the next accepted `iniciar` or `reset`. `acerto` and `erro` are never both 1.
- Strobes arriving in IDLE, CARREGA or FIM are ignored.
- `medida_pronto` arriving while in MEDE is ignored.

## Timing
- All outputs are registered.
- Reset value of every output is 0, state is IDLE, all counters are 0.
- `reset` mid-challenge → IDLE on the next edge, with no `pronto` pulse.
- `iniciar` high at edge t:
  - `ativo`=1 from t+1.
  - `leds`/`servo_*` valid from t+2.
  - Input is accepted from t+2.
- Char result: last `char_valid` at edge n → `acerto`/`erro` and `pronto` both visible after edge n+1.
- `pronto` is high for 1 cycle. `ativo` drops at the same edge that `pronto` rises.
- Measurement loop: `medir` pulse, then wait for any number of cycles for `medida_pronto`. The next `medir` comes 1 cycle after the strobe.
- Timeout: `erro` is asserted `TIMEOUT_CYCLES`+2 cycles after `iniciar`, worst case ±1.
- Minimum challenge: 6 cycles from `iniciar` to `pronto` (IDLE→CARREGA→4 chars at consecutive cycles→FIM).

## Test plan
- Text challenge: opcode 00, leds 0001, expected "A$0#" (0x41,0x24,0x30,0x23). Send those 4 chars → `leds`=0001, `servo_en`=0, `indice` steps 0→3, `pronto` with `acerto`=1, `erro`=0.
- Wrong char: same word, send 0x41,0x25 → `erro`=1 one cycle after the 0x25 strobe. Later chars are ignored. `estouro`=0.
- Servo challenge: opcode 10, pos_inicial 11, expected "C$1#" → `servo_en`=1 and `servo_pos`=11 while active. Both return to 0 after `pronto`; `acerto`=1.
- Sensor challenge: opcode 11, lim_inf 0x012, lim_sup 0x019, `CONSEC`=3. Send measurements 0x015, 0x020, 0x012, 0x019, 0x01A, 0x014, 0x016, 0x017 → the counter resets on 0x020 and on 0x01A (invalid digit). `acerto` asserts after 0x017, the 3rd consecutive in-range value.
- Timeout: `TIMEOUT_CYCLES`=20, text challenge with no chars → `erro`=`estouro`=1 at cycle 22±1. A `char_valid` forced on the expiry cycle still yields a timeout error.
- Reset and iniciar: assert `reset` after 2 correct chars → all outputs are 0 next cycle, no `pronto`. Pulse `iniciar` while `ativo` → no effect.

Source files
------------

// File: rtl/desafio_exec.sv
// Challenge executor: latches one challenge word and runs it to completion,
// checking either a 4-character serial answer or a run of in-range distance readings.
module desafio_exec #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CONSEC         = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [59:0] palavra,
    input  logic        char_valid,
    input  logic [6:0]  char_in,
    input  logic        medida_pronto,
    input  logic [11:0] medida,
    output logic        medir,
    output logic [3:0]  leds,
    output logic        servo_en,
    output logic [1:0]  servo_pos,
    output logic [1:0]  indice,
    output logic        ativo,
    output logic        pronto,
    output logic        acerto,
    output logic        erro,
    output logic        estouro
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    CMAX = 4'(CONSEC);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        CARREGA       = 3'd1,
        ESPERA_CHAR   = 3'd2,
        MEDE          = 3'd3,
        ESPERA_MEDIDA = 3'd4,
        FIM           = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [59:0]   word_q, word_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    cons_q, cons_d;
    logic          res_ok_q, res_ok_d;
    logic          res_to_q, res_to_d;
    logic [3:0]    leds_q, leds_d;
    logic          servo_en_q, servo_en_d;
    logic [1:0]    servo_pos_q, servo_pos_d;
    logic          ativo_q, ativo_d;
    logic          pronto_q, pronto_d;
    logic          acerto_q, acerto_d;
    logic          erro_q, erro_d;
    logic          estouro_q, estouro_d;
    logic          medir_q, medir_d;

    logic [6:0]    exp_char_s;
    logic          timeout_s;
    logic          in_range_s;
    logic [3:0]    cons_inc_s;

    function automatic logic bcd_ok(input logic [11:0] v);
        bcd_ok = (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Expected character selection, timeout detect and range check
    always_comb begin
        exp_char_s = 7'd0;
        case (idx_q)
            2'd0:    exp_char_s = word_q[27:21];
            2'd1:    exp_char_s = word_q[20:14];
            2'd2:    exp_char_s = word_q[13:7];
            2'd3:    exp_char_s = word_q[6:0];
            default: exp_char_s = 7'd0;
        endcase
        timeout_s  = (tmr_q == TMAX);
        in_range_s = bcd_ok(medida) && (medida >= word_q[51:40]) && (medida <= word_q[39:28]);
        cons_inc_s = cons_q + 4'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        cons_d      = cons_q;
        res_ok_d    = res_ok_q;
        res_to_d    = res_to_q;
        leds_d      = leds_q;
        servo_en_d  = servo_en_q;
        servo_pos_d = servo_pos_q;
        ativo_d     = ativo_q;
        pronto_d    = 1'b0;
        acerto_d    = acerto_q;
        erro_d      = erro_q;
        estouro_d   = estouro_q;
        medir_d     = 1'b0;

        case (state_q)
            IDLE: begin
                ativo_d = 1'b0;
                if (iniciar) begin
                    word_d    = palavra;
                    acerto_d  = 1'b0;
                    erro_d    = 1'b0;
                    estouro_d = 1'b0;
                    ativo_d   = 1'b1;
                    state_d   = CARREGA;
                end else begin
                    state_d = IDLE;
                end
            end
            CARREGA: begin
                leds_d   = word_q[57:54];
                tmr_d    = '0;
                idx_d    = 2'd0;
                cons_d   = 4'd0;
                res_ok_d = 1'b0;
                res_to_d = 1'b0;
                if ((word_q[59:58] == 2'b01) || (word_q[59:58] == 2'b10)) begin
                    servo_en_d  = 1'b1;
                    servo_pos_d = word_q[53:52];
                end else begin
                    servo_en_d  = 1'b0;
                    servo_pos_d = 2'd0;
                end
                if (word_q[59:58] == 2'b11) begin
                    state_d = MEDE;
                end else begin
                    state_d = ESPERA_CHAR;
                end
            end
            ESPERA_CHAR: begin
                if (timeout_s) begin
                    res_ok_d = 1'b0;
                    res_to_d = 1'b1;
                    state_d  = FIM;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                    if (char_valid) begin
                        if (char_in != exp_char_s) begin
                            res_ok_d = 1'b0;
                            state_d  = FIM;
                        end else if (idx_q == 2'd3) begin
                            res_ok_d = 1'b1;
                            state_d  = FIM;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = ESPERA_CHAR;
                    end
                end
            end
            MEDE: begin
                if (timeout_s) begin
                    res_ok_d = 1'b0;
                    res_to_d = 1'b1;
                    state_d  = FIM;
                end else begin
                    tmr_d   = tmr_q + TW'(1);
                    state_d = ESPERA_MEDIDA;
                end
            end
            ESPERA_MEDIDA: begin
                if (timeout_s) begin
                    res_ok_d = 1'b0;
                    res_to_d = 1'b1;
                    state_d  = FIM;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                    if (medida_pronto) begin
                        if (!in_range_s) begin
                            cons_d  = 4'd0;
                            state_d = MEDE;
                        end else if (cons_inc_s == CMAX) begin
                            cons_d   = cons_inc_s;
                            res_ok_d = 1'b1;
                            state_d  = FIM;
                        end else begin
                            cons_d  = cons_inc_s;
                            state_d = MEDE;
                        end
                    end else begin
                        state_d = ESPERA_MEDIDA;
                    end
                end
            end
            FIM: begin
                // Result flags publish together with the done pulse
                pronto_d    = 1'b1;
                ativo_d     = 1'b0;
                leds_d      = 4'd0;
                servo_en_d  = 1'b0;
                servo_pos_d = 2'd0;
                acerto_d    = res_ok_q;
                erro_d      = ~res_ok_q;
                estouro_d   = res_to_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == MEDE) begin
            medir_d = 1'b1;
        end else begin
            medir_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= 60'd0;
            tmr_q       <= '0;
            idx_q       <= 2'd0;
            cons_q      <= 4'd0;
            res_ok_q    <= 1'b0;
            res_to_q    <= 1'b0;
            leds_q      <= 4'd0;
            servo_en_q  <= 1'b0;
            servo_pos_q <= 2'd0;
            ativo_q     <= 1'b0;
            pronto_q    <= 1'b0;
            acerto_q    <= 1'b0;
            erro_q      <= 1'b0;
            estouro_q   <= 1'b0;
            medir_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            cons_q      <= cons_d;
            res_ok_q    <= res_ok_d;
            res_to_q    <= res_to_d;
            leds_q      <= leds_d;
            servo_en_q  <= servo_en_d;
            servo_pos_q <= servo_pos_d;
            ativo_q     <= ativo_d;
            pronto_q    <= pronto_d;
            acerto_q    <= acerto_d;
            erro_q      <= erro_d;
            estouro_q   <= estouro_d;
            medir_q     <= medir_d;
        end
    end

    assign medir     = medir_q;
    assign leds      = leds_q;
    assign servo_en  = servo_en_q;
    assign servo_pos = servo_pos_q;
    assign indice    = idx_q;
    assign ativo     = ativo_q;
    assign pronto    = pronto_q;
    assign acerto    = acerto_q;
    assign erro      = erro_q;
    assign estouro   = estouro_q;

endmodule
